// File: rtl/mole_spawner.sv
// Whack-a-mole spawner: game timing, LFSR mole pop-up, mole ageing, hit clearing and miss accounting.
module mole_spawner #(
  parameter int unsigned N_MOLES      = 18,
  parameter int unsigned SPAWN_PERIOD = 50_000_000,
  parameter int unsigned LIFE_TICKS   = 3,
  parameter int unsigned MAX_ACTIVE   = 4,
  parameter int unsigned GAME_TICKS   = 60,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_MOLES-1:0] hit_reg,
  output logic [N_MOLES-1:0] moles,
  output logic               running,
  output logic               game_over,
  output logic               miss_pulse,
  output logic [7:0]         miss_count,
  output logic [7:0]         ticks_left
);

  localparam int unsigned CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam int unsigned AGE_W = $clog2(LIFE_TICKS + 1);
  localparam int unsigned IDX_W = 5;

  localparam logic [15:0]      LFSR_TAPS = 16'hB400;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SPAWN_PERIOD - 1);
  localparam logic [AGE_W-1:0] AGE_ONE   = AGE_W'(1);
  localparam logic [AGE_W-1:0] AGE_FULL  = AGE_W'(LIFE_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_nx;
  logic [CNT_W-1:0]   cnt_q, cnt_nx;
  logic [15:0]        lfsr_q, lfsr_nx;
  logic [AGE_W-1:0]   age_q  [N_MOLES];
  logic [AGE_W-1:0]   age_nx [N_MOLES];
  logic [N_MOLES-1:0] moles_nx;
  logic               running_nx, game_over_nx, miss_pulse_nx;
  logic [7:0]         miss_count_nx, ticks_left_nx;

  logic               tick, last_tick, spawn_ok;
  logic [IDX_W-1:0]   spawn_idx;
  logic [N_MOLES-1:0] spawn_v, hit_v, exp_v, keep_v;
  int unsigned        n_exp, n_keep, miss_sum;

  function automatic int unsigned popcnt(input logic [N_MOLES-1:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < N_MOLES; i++) c += 32'(v[i]);
    return c;
  endfunction

  // Galois LFSR advance (x^16+x^14+x^13+x^11), free-running in every state
  always_comb begin
    lfsr_nx = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  // Game tick strobe: one cycle when the period counter wraps while running
  always_comb begin
    tick      = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
    last_tick = tick && (ticks_left == 8'd1);
  end

  // Spawn slot from the low LFSR bits, folded into the mole range, as a one-hot vector
  always_comb begin
    spawn_idx = lfsr_q[IDX_W-1:0];
    if (32'(lfsr_q[IDX_W-1:0]) >= N_MOLES)
      spawn_idx = IDX_W'(32'(lfsr_q[IDX_W-1:0]) - N_MOLES);
    spawn_v = '0;
    for (int unsigned i = 0; i < N_MOLES; i++)
      spawn_v[i] = (32'(spawn_idx) == i);
  end

  // Hits clear lit moles; on a tick, unhit moles at age 1 expire (hit wins over expiry)
  always_comb begin
    hit_v = (state_q == ST_RUN) ? (moles & hit_reg) : '0;
    exp_v = '0;
    for (int unsigned i = 0; i < N_MOLES; i++)
      if (tick && moles[i] && !hit_v[i] && (age_q[i] == AGE_ONE)) exp_v[i] = 1'b1;
    keep_v   = moles & ~hit_v & ~exp_v;
    n_exp    = popcnt(exp_v);
    n_keep   = popcnt(keep_v);
    miss_sum = 32'(miss_count) + n_exp;
    spawn_ok = tick && !last_tick && ((moles & spawn_v) == '0) &&
               (spawn_v != '0) && (n_keep < MAX_ACTIVE);
  end

  // Next-state and next-output logic for the game controller and mole datapath
  always_comb begin
    state_nx      = state_q;
    cnt_nx        = cnt_q;
    moles_nx      = moles;
    age_nx        = age_q;
    running_nx    = running;
    game_over_nx  = game_over;
    miss_pulse_nx = 1'b0;
    miss_count_nx = miss_count;
    ticks_left_nx = ticks_left;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        moles_nx = '0;
        for (int unsigned i = 0; i < N_MOLES; i++) age_nx[i] = '0;
        if (start) begin
          state_nx      = ST_RUN;
          running_nx    = 1'b1;
          game_over_nx  = 1'b0;
          ticks_left_nx = 8'(GAME_TICKS);
          miss_count_nx = '0;
          cnt_nx        = '0;
        end
      end

      ST_RUN: begin
        cnt_nx   = tick ? '0 : cnt_q + CNT_W'(1);
        moles_nx = keep_v;
        for (int unsigned i = 0; i < N_MOLES; i++) begin
          if (!keep_v[i])
            age_nx[i] = '0;
          else if (tick)
            age_nx[i] = age_q[i] - AGE_ONE;
        end
        if (tick) begin
          miss_pulse_nx = (n_exp != 0);
          miss_count_nx = (miss_sum > 32'd255) ? 8'hFF : miss_sum[7:0];
          ticks_left_nx = ticks_left - 8'd1;
          if (last_tick) begin
            state_nx     = ST_DONE;
            running_nx   = 1'b0;
            game_over_nx = 1'b1;
            moles_nx     = '0;
            for (int unsigned i = 0; i < N_MOLES; i++) age_nx[i] = '0;
          end else if (spawn_ok) begin
            moles_nx = keep_v | spawn_v;
            for (int unsigned i = 0; i < N_MOLES; i++)
              if (spawn_v[i]) age_nx[i] = AGE_FULL;
          end
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nx;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      lfsr_q     <= LFSR_SEED;
      moles      <= '0;
      running    <= 1'b0;
      game_over  <= 1'b0;
      miss_pulse <= 1'b0;
      miss_count <= '0;
      ticks_left <= '0;
      for (int unsigned i = 0; i < N_MOLES; i++) age_q[i] <= '0;
    end else begin
      cnt_q      <= cnt_nx;
      lfsr_q     <= lfsr_nx;
      moles      <= moles_nx;
      running    <= running_nx;
      game_over  <= game_over_nx;
      miss_pulse <= miss_pulse_nx;
      miss_count <= miss_count_nx;
      ticks_left <= ticks_left_nx;
      for (int unsigned i = 0; i < N_MOLES; i++) age_q[i] <= age_nx[i];
    end
  end

endmodule

// File: tb/tb_mole_spawner.sv
// Self-checking bench for mole_spawner: reference game model feeds an expected-output queue.
module tb_mole_spawner;

  localparam int N    = 18;
  localparam int SP   = 4;
  localparam int LT   = 3;
  localparam int MA   = 2;
  localparam int GT   = 10;
  localparam logic [15:0] SEED = 16'hACE1;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b1;
  logic         start   = 1'b0;
  logic [N-1:0] hit_reg = '0;
  logic [N-1:0] moles;
  logic         running, game_over, miss_pulse;
  logic [7:0]   miss_count, ticks_left;

  mole_spawner #(
    .N_MOLES(N), .SPAWN_PERIOD(SP), .LIFE_TICKS(LT),
    .MAX_ACTIVE(MA), .GAME_TICKS(GT), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hit_reg(hit_reg),
    .moles(moles), .running(running), .game_over(game_over),
    .miss_pulse(miss_pulse), .miss_count(miss_count), .ticks_left(ticks_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] moles;
    logic         running;
    logic         game_over;
    logic         miss_pulse;
    logic [7:0]   miss_count;
    logic [7:0]   ticks_left;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  // Reference game model (0=idle, 1=run, 2=done)
  int           m_state, m_cnt, m_ticks, m_miss, m_idx, m_expired;
  int           m_age [N];
  logic [N-1:0] m_moles, m_old;
  logic         m_pulse, m_is_tick;
  logic [15:0]  m_lfsr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_cnt = 0; m_ticks = 0; m_miss = 0; m_pulse = 1'b0;
      m_moles = '0; m_lfsr = SEED;
      for (int i = 0; i < N; i++) m_age[i] = 0;
      exp_q.delete();
    end else begin
      m_old   = m_moles;
      m_pulse = 1'b0;
      if (m_state != 1) begin
        if (start) begin
          m_state = 1; m_ticks = GT; m_miss = 0; m_cnt = 0; m_moles = '0;
          for (int i = 0; i < N; i++) m_age[i] = 0;
        end
      end else begin
        m_is_tick = (m_cnt == SP - 1);
        m_cnt = m_is_tick ? 0 : m_cnt + 1;
        for (int i = 0; i < N; i++)
          if (m_moles[i] && hit_reg[i]) begin m_moles[i] = 1'b0; m_age[i] = 0; end
        if (m_is_tick) begin
          m_expired = 0;
          for (int i = 0; i < N; i++) begin
            if (m_moles[i]) begin
              if (m_age[i] == 1) begin
                m_moles[i] = 1'b0; m_age[i] = 0; m_expired++;
              end else begin
                m_age[i] = m_age[i] - 1;
              end
            end
          end
          m_miss  = (m_miss + m_expired > 255) ? 255 : m_miss + m_expired;
          m_pulse = (m_expired != 0);
          m_ticks = m_ticks - 1;
          if (m_ticks == 0) begin
            m_state = 2; m_moles = '0;
            for (int i = 0; i < N; i++) m_age[i] = 0;
          end else begin
            m_idx = int'(m_lfsr[4:0]);
            if (m_idx >= N) m_idx = m_idx - N;
            if (!m_old[m_idx] && $countones(m_moles) < MA) begin
              m_moles[m_idx] = 1'b1; m_age[m_idx] = LT;
            end
          end
        end
      end
      if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
      else           m_lfsr = m_lfsr >> 1;
      exp_q.push_back('{moles: m_moles, running: (m_state == 1), game_over: (m_state == 2),
                        miss_pulse: m_pulse, miss_count: 8'(m_miss), ticks_left: 8'(m_ticks)});
    end
  end

  // Advance one clock and take the model's expectation for the new outputs
  task automatic step();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      cur = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({moles, running, game_over, miss_pulse} !== '0) begin
      errors++; $display("FAIL reset_flags: got %h/%b/%b/%b expected 0", moles, running, game_over, miss_pulse);
    end
    checks++;
    if ({miss_count, ticks_left} !== 16'h0) begin
      errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", miss_count, ticks_left);
    end
    rst_n = 1'b1;
    repeat (20) begin
      step();
      checks++;
      if (moles !== cur.moles || running !== cur.running) begin
        errors++; $display("FAIL idle_sb: got %h/%b expected %h/%b", moles, running, cur.moles, cur.running);
      end
    end
    checks++;
    if (moles !== '0 || running !== 1'b0 || game_over !== 1'b0 || miss_count !== 8'd0) begin
      errors++; $display("FAIL idle_20: got %h/%b/%b/%0d expected 0/0/0/0", moles, running, game_over, miss_count);
    end
  endtask

  task automatic test_start_spawn();
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (running !== 1'b1 || ticks_left !== 8'd10 || moles !== '0) begin
      errors++; $display("FAIL start: got run=%b ticks=%0d moles=%h expected 1/10/0", running, ticks_left, moles);
    end
    repeat (SP) step();
    checks++;
    if ($countones(moles) != 1) begin
      errors++; $display("FAIL first_spawn_count: got %0d expected 1", $countones(moles));
    end
    checks++;
    if (moles !== cur.moles) begin
      errors++; $display("FAIL first_spawn_idx: got %h expected %h", moles, cur.moles);
    end
  endtask

  task automatic test_expiry();
    int dut_pulses = 0;
    int mdl_pulses = 0;
    repeat (20) begin
      step();
      if (miss_pulse === 1'b1) dut_pulses++;
      if (cur.miss_pulse) mdl_pulses++;
      checks++;
      if (moles !== cur.moles || miss_pulse !== cur.miss_pulse || miss_count !== cur.miss_count) begin
        errors++; $display("FAIL expiry_sb: got %h/%b/%0d expected %h/%b/%0d",
                           moles, miss_pulse, miss_count, cur.moles, cur.miss_pulse, cur.miss_count);
      end
      checks++;
      if ($countones(moles) > MA) begin
        errors++; $display("FAIL max_active: got %0d expected <= %0d", $countones(moles), MA);
      end
    end
    checks++;
    if (dut_pulses != mdl_pulses || dut_pulses == 0) begin
      errors++; $display("FAIL miss_pulses: got %0d expected %0d (nonzero)", dut_pulses, mdl_pulses);
    end
  endtask

  task automatic test_game_over();
    bit done = 0;
    for (int n = 0; n < 80 && !done; n++) begin
      step();
      checks++;
      if (moles !== cur.moles || ticks_left !== cur.ticks_left || game_over !== cur.game_over) begin
        errors++; $display("FAIL run_sb: got %h/%0d/%b expected %h/%0d/%b",
                           moles, ticks_left, game_over, cur.moles, cur.ticks_left, cur.game_over);
      end
      if (game_over === 1'b1) done = 1;
    end
    checks++;
    if (!done || moles !== '0 || ticks_left !== 8'd0 || running !== 1'b0) begin
      errors++; $display("FAIL game_done: got go=%b moles=%h ticks=%0d run=%b expected 1/0/0/0",
                         game_over, moles, ticks_left, running);
    end
    checks++;
    if (miss_count !== cur.miss_count) begin
      errors++; $display("FAIL final_misses: got %0d expected %0d", miss_count, cur.miss_count);
    end
    hit_reg = '1;
    repeat (3) step();
    hit_reg = '0;
    checks++;
    if (moles !== '0 || game_over !== 1'b1 || ticks_left !== 8'd0) begin
      errors++; $display("FAIL done_hold: got %h/%b/%0d expected 0/1/0", moles, game_over, ticks_left);
    end
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (running !== 1'b1 || game_over !== 1'b0 || miss_count !== 8'd0 || ticks_left !== 8'd10) begin
      errors++; $display("FAIL restart: got %b/%b/%0d/%0d expected 1/0/0/10", running, game_over, miss_count, ticks_left);
    end
  endtask

  task automatic test_ignore();
    logic [N-1:0] snap;
    hit_reg = '1;
    repeat (2) begin
      step();
      checks++;
      if (moles !== '0 || moles !== cur.moles) begin
        errors++; $display("FAIL hit_unlit: got %h expected 0", moles);
      end
    end
    hit_reg = '0;
    repeat (2) step();
    checks++;
    if ($countones(moles) != 1 || ticks_left !== 8'd9 || moles !== cur.moles) begin
      errors++; $display("FAIL tick_after_ignore: got %h/%0d expected %h/9", moles, ticks_left, cur.moles);
    end
    snap = cur.moles;
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (running !== 1'b1 || ticks_left !== 8'd9 || moles !== snap) begin
      errors++; $display("FAIL start_in_run: got %b/%0d/%h expected 1/9/%h", running, ticks_left, moles, snap);
    end
  endtask

  task automatic test_hit_on_expiry();
    logic [N-1:0] target;
    logic [7:0]   prev_miss;
    bit found = 0;
    for (int n = 0; n < 60 && !found; n++) begin
      target = '0;
      for (int i = 0; i < N; i++) if (m_moles[i] && m_age[i] == 1) target[i] = 1'b1;
      if (m_state == 1 && m_cnt == SP - 1 && target != '0) begin
        prev_miss = cur.miss_count;
        hit_reg = moles;
        step();
        hit_reg = '0;
        found = 1;
        checks++;
        if ((moles & target) !== '0 || moles !== cur.moles) begin
          errors++; $display("FAIL hit_wins_clear: got %h expected %h", moles, cur.moles);
        end
        checks++;
        if (miss_pulse !== 1'b0 || miss_count !== prev_miss) begin
          errors++; $display("FAIL hit_wins_miss: got %b/%0d expected 0/%0d", miss_pulse, miss_count, prev_miss);
        end
      end else begin
        step();
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL hit_wins_search: got no age-1 tick expected one within 60 cycles");
    end
  endtask

  task automatic test_reset_mid();
    repeat (2) step();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({moles, running, game_over, miss_pulse} !== '0 || {miss_count, ticks_left} !== 16'h0) begin
      errors++; $display("FAIL async_reset: got %h/%b/%b/%b/%0d/%0d expected all 0",
                         moles, running, game_over, miss_pulse, miss_count, ticks_left);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step();
    start = 1'b1; step(); start = 1'b0;
    repeat (SP) step();
    checks++;
    if ($countones(moles) != 1 || moles !== cur.moles) begin
      errors++; $display("FAIL reseed_spawn: got %h expected %h", moles, cur.moles);
    end
  endtask

  initial begin
    test_reset();
    test_start_spawn();
    test_expiry();
    test_game_over();
    test_ignore();
    test_hit_on_expiry();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
